// File: rtl/instruction_sequencer.sv
// id_pkg: CPU opcode set shared with the downstream decoder.
package id_pkg;
  typedef enum logic [3:0] {
    LOAD  = 4'h0,
    STORE = 4'h1,
    ADD   = 4'h2,
    SUB   = 4'h3,
    AND_OP = 4'h4,
    OR_OP  = 4'h5,
    XOR_OP = 4'h6,
    JMP   = 4'h7,
    NOP   = 4'hF
  } cpu_instructions;
endpackage

// instruction_sequencer: issues a loaded program one word per cycle.
//   clk, rst                         : clock, synchronous active-high reset
//   load_en/load_addr/load_data      : program-memory write port (IDLE only)
//   prog_len                         : word count, sampled on an accepted start
//   start / abort / stall            : run control
//   instruction, instr_valid         : registered issue to the decoder
//   pc                               : address of the next word to issue
//   busy, done                       : RUN indicator, one-cycle completion pulse
module instruction_sequencer
  import id_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned IW     = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [IW-1:0]     load_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic              stall,
  output logic [IW-1:0]     instruction,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [IW-1:0] NOP_WORD = IW'({NOP, 2'b00});

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t             state, state_nxt;
  logic [LEN_W-1:0]   issued;
  logic [LEN_W-1:0]   len;
  logic [LEN_W-1:0]   start_len;
  logic [IW-1:0]      mem [DEPTH];

  // Requested length clamped to the memory depth.
  assign start_len = (prog_len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : prog_len;

  // Program memory; intentionally not reset so a program survives rst/abort.
  always_ff @(posedge clk) begin
    if (load_en && (state == S_IDLE)) begin
      mem[load_addr] <= load_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = (start_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (abort)              state_nxt = S_IDLE;
        else if (issued == len) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State decode outputs.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Issue datapath: every non-issuing edge drives a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= '0;
      issued      <= '0;
      len         <= '0;
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
    end else begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            pc     <= '0;
            issued <= '0;
            len    <= start_len;
          end
        end
        S_RUN: begin
          if (!abort && !stall && (issued < len)) begin
            instruction <= mem[pc];
            instr_valid <= 1'b1;
            pc          <= pc + ADDR_W'(1);
            issued      <= issued + LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_sequencer.sv
// Randomized bench: program-level reference model (expected word stream
// from a shadow memory) compared against the sequencer cycle by cycle.
module tb_instruction_sequencer;
  import id_pkg::*;

  localparam logic [5:0] NOP_W = {NOP, 2'b00};

  logic       clk = 1'b0;
  logic       rst, load_en, start, abort, stall;
  logic [3:0] load_addr;
  logic [5:0] load_data;
  logic [4:0] prog_len;
  logic [5:0] instruction;
  logic       instr_valid, busy, done;
  logic [3:0] pc;

  logic [5:0] mm [16];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  instruction_sequencer #(.ADDR_W(4), .IW(6)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .prog_len(prog_len), .start(start),
    .abort(abort), .stall(stall), .instruction(instruction),
    .instr_valid(instr_valid), .pc(pc), .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_bubble(input string tag);
    check({tag, "_valid"}, 32'(instr_valid), 32'd0);
    check({tag, "_instr"}, 32'(instruction), 32'(NOP_W));
  endtask

  task automatic load_word(input logic [3:0] a, input logic [5:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
    mm[a] = d;
  endtask

  // One program run; the expected stream is mm[0..n-1] with stalls as bubbles.
  task automatic run(input int plen, input logic [63:0] smask, input int abort_at,
                     input int rst_at, input bit load_on_start, input bit noise);
    int n, idx;
    bit fin, st;
    logic [3:0] la;
    logic [5:0] ld;
    n = (plen > 16) ? 16 : plen;
    idx = 0;
    fin = 0;
    @(negedge clk);
    start = 1'b1; prog_len = 5'(plen);
    if (load_on_start) begin
      la = 4'($urandom); ld = 6'($urandom);
      load_en = 1'b1; load_addr = la; load_data = ld;
      mm[la] = ld;
    end
    @(posedge clk); #1;
    start = 1'b0; load_en = 1'b0;
    if (n == 0) begin
      check("zero_done", 32'(done), 32'd1);
      check("zero_busy", 32'(busy), 32'd0);
      check_bubble("zero");
      @(posedge clk); #1;
      check("zero_after_done", 32'(done), 32'd0);
      check("zero_after_busy", 32'(busy), 32'd0);
      check_bubble("zero_after");
      return;
    end
    check("start_busy", 32'(busy), 32'd1);
    check("start_pc", 32'(pc), 32'd0);
    check("start_done", 32'(done), 32'd0);
    check_bubble("start");
    for (int c = 0; c < 100 && !fin; c++) begin
      st = (c < 64) ? smask[c] : 1'b0;
      @(negedge clk);
      stall = st; abort = (c == abort_at); rst = (c == rst_at);
      if (noise) begin
        load_en = 1'($urandom); load_addr = 4'($urandom); load_data = 6'($urandom);
        start = 1'($urandom); prog_len = 5'($urandom);
      end
      @(posedge clk); #1;
      stall = 1'b0; abort = 1'b0; rst = 1'b0; load_en = 1'b0; start = 1'b0;
      if (c == rst_at) begin
        check_bubble("rst");
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        fin = 1;
      end else if (c == abort_at) begin
        check_bubble("abort");
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        fin = 1;
      end else if (idx == n) begin
        check_bubble("end");
        check("end_done", 32'(done), 32'd1);
        check("end_busy", 32'(busy), 32'd0);
        check("end_pc", 32'(pc), 32'(n % 16));
        @(negedge clk);
        start = 1'b1; prog_len = 5'd4;
        @(posedge clk); #1;
        start = 1'b0;
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check("idle_pc", 32'(pc), 32'(n % 16));
        fin = 1;
      end else if (st) begin
        check_bubble("stall");
        check("stall_pc", 32'(pc), 32'(idx % 16));
        check("stall_busy", 32'(busy), 32'd1);
      end else begin
        check("issue_valid", 32'(instr_valid), 32'd1);
        check("issue_instr", 32'(instruction), 32'(mm[idx]));
        idx++;
        check("issue_pc", 32'(pc), 32'(idx % 16));
        check("issue_busy", 32'(busy), 32'd1);
      end
    end
    if (!fin) check("timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int pl, ab, rs;
    logic [63:0] sm;
    rst = 1'b1; load_en = 1'b0; start = 1'b0; abort = 1'b0; stall = 1'b0;
    load_addr = '0; load_data = '0; prog_len = '0;
    repeat (2) @(posedge clk);
    #1;
    check_bubble("reset");
    check("reset_pc", 32'(pc), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Known contents everywhere, distinct in the first four words.
    for (int i = 0; i < 16; i++) load_word(4'(i), 6'(i * 3 + 1));

    run(4, 64'd0, -1, -1, 0, 0);                 // basic program
    run(4, 64'h0c, -1, -1, 0, 0);                // two bubbles after word 1
    run(0, 64'd0, -1, -1, 0, 0);                 // empty program
    run(20, 64'd0, -1, -1, 0, 0);                // clamped to full depth, pc wraps
    run(4, 64'd0, 2, -1, 0, 0);                  // abort while issuing word 2
    run(4, 64'd0, -1, -1, 0, 0);                 // memory intact after abort
    run(8, 64'h5, -1, 2, 0, 1);                  // reset mid-run with load/start noise
    run(16, 64'h0, -1, -1, 0, 0);                // memory intact after reset
    run(3, 64'h0, -1, -1, 1, 0);                 // load coinciding with start

    for (int t = 0; t < 40; t++) begin
      for (int k = $urandom_range(0, 3); k > 0; k--) load_word(4'($urandom), 6'($urandom));
      pl = $urandom_range(0, 20);
      sm = {$urandom, $urandom} & {$urandom, $urandom};
      ab = -1; rs = -1;
      case ($urandom_range(0, 5))
        0: ab = $urandom_range(0, 24);
        1: rs = $urandom_range(0, 24);
        default: ;
      endcase
      run(pl, sm, ab, rs, 1'($urandom), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
